// File: rtl/td4_run_ctrl_if.sv
// Board-side control/status bundle of the TD4 run controller.
// Master drives switches, button and PC; slave returns CE and status.
interface td4_run_ctrl_if;
  logic [1:0]  MODE_I;
  logic        STEP_I;
  logic        BRK_EN_I;
  logic [3:0]  BRK_ADDR_I;
  logic [3:0]  PC_I;
  logic        TD4_CE_O;
  logic [1:0]  STATE_O;
  logic        BRK_HIT_O;
  logic [15:0] CE_CNT_O;

  modport master (
    output MODE_I, STEP_I, BRK_EN_I, BRK_ADDR_I, PC_I,
    input  TD4_CE_O, STATE_O, BRK_HIT_O, CE_CNT_O
  );

  modport slave (
    input  MODE_I, STEP_I, BRK_EN_I, BRK_ADDR_I, PC_I,
    output TD4_CE_O, STATE_O, BRK_HIT_O, CE_CNT_O
  );
endinterface

// File: rtl/td4_run_ctrl.sv
// TD4 execution sequencer: halt / slow / fast / single-step CE pulses,
// 4-bit PC breakpoint and a wrapping count of issued CEs.
module td4_run_ctrl #(
  parameter int unsigned DIV_SLOW     = 50_000_000,
  parameter int unsigned DIV_FAST     = 5_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  td4_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_mode_s1;
  logic [1:0]  r_mode_s2;
  logic [1:0]  r_mode_prev;
  logic        r_step_s1;
  logic        r_step_s2;
  logic [31:0] r_db_cnt;
  logic        r_db_lvl;
  logic        r_db_prev;
  logic        r_press;
  logic [31:0] r_pre;
  logic [31:0] w_pre_nxt;
  logic [31:0] w_div_m1;
  logic        r_ce;
  logic        w_ce_nxt;
  logic        r_hit;
  logic        w_hit_nxt;
  logic [15:0] r_cnt;
  logic        w_mode_chg;
  logic        w_tick;
  logic        w_brk_match;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
    end else begin
      r_mode_s1 <= bus.MODE_I;
      r_mode_s2 <= r_mode_s1;
      r_step_s1 <= bus.STEP_I;
      r_step_s2 <= r_step_s1;
    end
  end

  // Press is registered once more so CE lands one cycle after detection.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_db_cnt  <= '0;
      r_db_lvl  <= 1'b0;
      r_db_prev <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_db_prev <= r_db_lvl;
      r_press   <= r_db_lvl & ~r_db_prev;
      if (r_step_s2 == r_db_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DEBOUNCE_CYC - 32'd1) begin
        r_db_lvl <= r_step_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 32'd1;
      end
    end
  end

  assign w_mode_chg  = (r_mode_s2 != r_mode_prev);
  assign w_div_m1    = (r_mode_prev == 2'b10) ? DIV_FAST - 32'd1
                                              : DIV_SLOW - 32'd1;
  assign w_tick      = (r_pre == w_div_m1);
  assign w_brk_match = bus.BRK_EN_I && (bus.PC_I == bus.BRK_ADDR_I);

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_ce_nxt    = 1'b0;
    w_hit_nxt   = r_hit;
    if (w_mode_chg) begin
      w_pre_nxt = '0;
      w_hit_nxt = 1'b0;
      unique case (1'b1)
        (r_mode_s2 == 2'b00): w_state_nxt = S_HALT;
        (r_mode_s2 == 2'b11): w_state_nxt = S_STEP;
        default:              w_state_nxt = S_RUN;
      endcase
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_tick) begin
            w_pre_nxt = '0;
            if (w_brk_match) begin
              w_state_nxt = S_BREAK;
              w_hit_nxt   = 1'b1;
            end else begin
              w_ce_nxt = 1'b1;
            end
          end else begin
            w_pre_nxt = r_pre + 32'd1;
          end
        end
        S_STEP: w_ce_nxt = r_press;
        // The resuming CE runs the breakpoint instruction uncompared.
        S_BREAK: begin
          w_pre_nxt = '0;
          if (r_press) begin
            w_ce_nxt    = 1'b1;
            w_state_nxt = S_RUN;
            w_hit_nxt   = 1'b0;
          end
        end
        S_HALT: w_ce_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state     <= S_HALT;
      r_mode_prev <= 2'b00;
      r_pre       <= '0;
      r_ce        <= 1'b0;
      r_hit       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_prev <= r_mode_s2;
      r_pre       <= w_pre_nxt;
      r_ce        <= w_ce_nxt;
      r_hit       <= w_hit_nxt;
      if (w_ce_nxt) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.TD4_CE_O  = r_ce;
  assign bus.STATE_O   = r_state;
  assign bus.BRK_HIT_O = r_hit;
  assign bus.CE_CNT_O  = r_cnt;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_td4_run_ctrl;

  localparam int DS = 8;
  localparam int DF = 2;
  localparam int DB = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst2_n = 1'b1;
  always #5 clk = ~clk;

  td4_run_ctrl_if bus();
  td4_run_ctrl_if bus2();

  td4_run_ctrl #(
    .DIV_SLOW(DS), .DIV_FAST(DF), .DEBOUNCE_CYC(DB)
  ) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(bus)
  );

  // Second instance with DIV_FAST=1: one CE per cycle reaches the wrap fast.
  td4_run_ctrl #(
    .DIV_SLOW(DS), .DIV_FAST(1), .DEBOUNCE_CYC(DB)
  ) dut2 (
    .CLK_I(clk), .RST_N_I(rst2_n), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit pc_follow = 1'b0;
  logic [3:0] pc_fix = 4'd0;

  always @(posedge clk) begin
    #1;
    bus.PC_I = pc_follow ? bus.CE_CNT_O[3:0] : pc_fix;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int e = 0;
  int m_hm[2];
  int m_hs[2];
  int m_lvl, m_run, m_due;
  int m_state, m_prev, m_base, m_ce, m_hit, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hm = '{0, 0};
      m_hs = '{0, 0};
      m_lvl = 0; m_run = 0; m_due = -1;
      m_state = 0; m_prev = 0; m_base = 0;
      m_ce = 0; m_hit = 0; m_cnt = 0;
    end else begin
      int sm;
      int ss;
      int div;
      bit press;
      e++;
      sm = m_hm[1];
      ss = m_hs[1];
      m_hm[1] = m_hm[0];
      m_hm[0] = int'(bus.MODE_I);
      m_hs[1] = m_hs[0];
      m_hs[0] = int'(bus.STEP_I);
      press = (m_due == e);
      if (ss != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = ss;
          m_run = 0;
          if (ss == 1) m_due = e + 2;
        end
      end else begin
        m_run = 0;
      end
      m_ce = 0;
      if (sm != m_prev) begin
        m_prev = sm;
        m_base = e;
        m_hit = 0;
        m_state = (sm == 0) ? 0 : (sm == 3) ? 2 : 1;
      end else begin
        case (m_state)
          1: begin
            div = (m_prev == 2) ? DF : DS;
            if ((e - m_base) % div == 0) begin
              if (bus.BRK_EN_I && bus.PC_I == bus.BRK_ADDR_I) begin
                m_state = 3;
                m_hit = 1;
              end else begin
                m_ce = 1;
              end
            end
          end
          2: if (press) m_ce = 1;
          3: if (press) begin
            m_ce = 1;
            m_state = 1;
            m_base = e;
            m_hit = 0;
          end
          default: ;
        endcase
      end
      if (m_ce == 1) m_cnt = (m_cnt + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (int'(bus.TD4_CE_O) != m_ce || int'(bus.STATE_O) != m_state ||
          int'(bus.BRK_HIT_O) != m_hit || int'(bus.CE_CNT_O) != m_cnt) begin
        errors++;
        $display("FAIL model t=%0t ce %0d/%0d st %0d/%0d hit %0d/%0d cnt %0d/%0d",
                 $time, bus.TD4_CE_O, m_ce, bus.STATE_O, m_state,
                 bus.BRK_HIT_O, m_hit, bus.CE_CNT_O, m_cnt);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.MODE_I = 2'b00;
    bus.STEP_I = 1'b0;
    bus.BRK_EN_I = 1'b0;
    bus.BRK_ADDR_I = 4'd0;
    pc_follow = 1'b0;
    pc_fix = 4'd0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ce(input int lim, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.TD4_CE_O && n < lim);
  endtask

  task automatic wait_st(input int st, input int lim, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (int'(bus.STATE_O) != st && n < lim);
  endtask

  task automatic count_ce(input int len, output int nce);
    nce = 0;
    repeat (len) begin
      cyc(1);
      if (bus.TD4_CE_O) nce++;
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ce"}, int'(bus.TD4_CE_O), 0);
    chk({tag, "_state"}, int'(bus.STATE_O), 0);
    chk({tag, "_hit"}, int'(bus.BRK_HIT_O), 0);
    chk({tag, "_cnt"}, int'(bus.CE_CNT_O), 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         w;
    int         st;
    int         cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic main_seq();
    int n;
    int nce;
    int first;
    tbl[0] = '{2'b00, 20, 0, 0};
    tbl[1] = '{2'b01, 20, 1, 2};
    tbl[2] = '{2'b10, 20, 1, 8};
    tbl[3] = '{2'b11, 20, 2, 0};
    tbl[4] = '{2'b01, 10, 1, 0};
    tbl[5] = '{2'b01, 11, 1, 1};
    tbl[6] = '{2'b10, 5, 1, 1};
    tbl[7] = '{2'b10, 4, 1, 0};
    tbl[8] = '{2'b01, 2, 0, 0};
    tbl[9] = '{2'b11, 3, 2, 0};

    #2;
    rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk_rst_vals("reset");
    do_reset();

    foreach (tbl[i]) begin
      do_reset();
      bus.MODE_I = tbl[i].mode;
      cyc(tbl[i].w);
      chk($sformatf("tbl%0d_state", i), int'(bus.STATE_O), tbl[i].st);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.CE_CNT_O), tbl[i].cnt);
    end

    // T1 slow run cadence
    do_reset();
    bus.MODE_I = 2'b01;
    wait_st(1, 20, n);
    chk("t1_entry", n, 3);
    for (int k = 1; k <= 3; k++) begin
      wait_ce(20, n);
      chk("t1_gap", n, 8);
      chk("t1_cnt", int'(bus.CE_CNT_O), k);
    end

    // T2 bouncy step press
    do_reset();
    bus.MODE_I = 2'b11;
    cyc(3);
    chk("t2_state", int'(bus.STATE_O), 2);
    bus.STEP_I = 1'b1; cyc(2);
    bus.STEP_I = 1'b0; cyc(2);
    bus.STEP_I = 1'b1;
    nce = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (bus.TD4_CE_O) begin
        nce++;
        if (first == 0) first = i;
      end
    end
    chk("t2_first", first, 8);
    chk("t2_count", nce, 1);
    bus.STEP_I = 1'b0;
    count_ce(15, nce);
    chk("t2_release", nce, 0);

    // T3 breakpoint, resume, self-jump rebreak
    do_reset();
    bus.BRK_EN_I = 1'b1;
    bus.BRK_ADDR_I = 4'd3;
    pc_follow = 1'b1;
    bus.MODE_I = 2'b10;
    wait_st(3, 60, n);
    chk("t3_lat", n, 11);
    chk("t3_cnt", int'(bus.CE_CNT_O), 3);
    chk("t3_hit", int'(bus.BRK_HIT_O), 1);
    count_ce(4, nce);
    chk("t3_hold", nce, 0);
    pc_follow = 1'b0;
    pc_fix = 4'd3;
    bus.STEP_I = 1'b1;
    wait_ce(20, n);
    chk("t3_press", n, 8);
    chk("t3_run", int'(bus.STATE_O), 1);
    chk("t3_cnt4", int'(bus.CE_CNT_O), 4);
    chk("t3_hitclr", int'(bus.BRK_HIT_O), 0);
    wait_st(3, 10, n);
    chk("t3_rebreak", n, 2);
    bus.STEP_I = 1'b0;
    count_ce(12, nce);
    chk("t3_norel", nce, 0);
    chk("t3_stay", int'(bus.STATE_O), 3);

    // T4 halt mid-prescale, then resume
    do_reset();
    bus.MODE_I = 2'b01;
    wait_st(1, 20, n);
    cyc(5);
    bus.MODE_I = 2'b00;
    count_ce(30, nce);
    chk("t4_noce", nce, 0);
    chk("t4_halt", int'(bus.STATE_O), 0);
    bus.MODE_I = 2'b01;
    wait_st(1, 20, n);
    chk("t4_entry", n, 3);
    wait_ce(20, n);
    chk("t4_first", n, 8);

    // T6 reset during BREAK and during a debounce count
    do_reset();
    bus.BRK_EN_I = 1'b1;
    bus.BRK_ADDR_I = 4'd3;
    pc_follow = 1'b1;
    bus.MODE_I = 2'b10;
    wait_st(3, 60, n);
    rst_n = 1'b0;
    #1;
    chk_rst_vals("t6_brk");
    cyc(2);
    bus.MODE_I = 2'b00;
    rst_n = 1'b1;
    bus.STEP_I = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk_rst_vals("t6_db");
    cyc(1);
    rst_n = 1'b1;
    count_ce(20, nce);
    chk("t6_nospur", nce, 0);
    chk("t6_halt", int'(bus.STATE_O), 0);

    // randomized traffic, model compares every cycle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 2) bus.MODE_I = 2'($urandom_range(3));
      if ($urandom_range(99) < 8) bus.STEP_I = ~bus.STEP_I;
      if ($urandom_range(99) < 3) begin
        bus.BRK_EN_I = 1'($urandom_range(1));
        bus.BRK_ADDR_I = 4'($urandom_range(15));
      end
      pc_follow = ($urandom_range(3) != 0);
      pc_fix = 4'($urandom_range(15));
      if ($urandom_range(999) < 2) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end
  endtask

  // T5 count wrap on the DIV_FAST=1 instance
  task automatic wrap_seq();
    int n;
    bus2.MODE_I = 2'b10;
    bus2.STEP_I = 1'b0;
    bus2.BRK_EN_I = 1'b0;
    bus2.BRK_ADDR_I = 4'd0;
    bus2.PC_I = 4'd0;
    #2;
    rst2_n = 1'b0;
    cyc(2);
    rst2_n = 1'b1;
    n = 0;
    while (bus2.CE_CNT_O != 16'hFFFF && n < 70000) begin
      cyc(1);
      n++;
    end
    chk("t5_cycles", n, 65538);
    chk("t5_ffff", int'(bus2.CE_CNT_O), 65535);
    chk("t5_ce_hi", int'(bus2.TD4_CE_O), 1);
    cyc(1);
    chk("t5_wrap", int'(bus2.CE_CNT_O), 0);
    chk("t5_ce_b2b", int'(bus2.TD4_CE_O), 1);
  endtask

  initial begin
    fork
      main_seq();
      wrap_seq();
    join
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
